// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between MEM/WB writeback and a multi-cycle producer,
// with a one-entry holding buffer whose age forces a pipeline stall when it has lost arbitration too long.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            mc_valid,
    input  logic [4:0]      mc_rd,
    input  logic [XLEN-1:0] mc_data,
    output logic            mc_ready,
    output logic            pipe_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            waw_drop
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic            buf_valid_q, buf_valid_d;
    logic [4:0]      buf_rd_q, buf_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [3:0]      starve_q, starve_d;
    logic            p_req, m_req, forced, grant_buf, grant_p, bypass;
    logic            kill_buf, kill_m, load, clear;
    always_comb begin
        p_req     = !rst && wb_valid && wb_rd != 5'd0;
        m_req     = mc_valid && mc_ready && mc_rd != 5'd0;
        forced    = !rst && buf_valid_q && starve_q == LIMIT;
        grant_buf = forced || (!rst && buf_valid_q && !p_req);
        grant_p   = p_req && !forced;
        bypass    = m_req && !p_req;
        kill_buf  = grant_p && buf_valid_q && buf_rd_q == wb_rd;
        kill_m    = grant_p && m_req && mc_rd == wb_rd;
        load      = grant_p && m_req && !kill_m;
        clear     = grant_buf || kill_buf;
    end
    assign mc_ready   = !buf_valid_q && !rst;
    assign pipe_stall = forced && p_req;
    assign waw_drop   = kill_buf || kill_m;
    assign rf_we      = grant_buf || grant_p || bypass;
    assign rf_waddr   = grant_buf ? buf_rd_q : grant_p ? wb_rd : bypass ? mc_rd : 5'd0;
    assign rf_wdata   = grant_buf ? buf_data_q : grant_p ? wb_data : bypass ? mc_data : '0;
    // A buffer load only happens when it was empty, so load and clear never coincide.
    always_comb begin
        buf_valid_d = clear ? 1'b0 : load ? 1'b1 : buf_valid_q;
        buf_rd_d    = load ? mc_rd : buf_rd_q;
        buf_data_d  = load ? mc_data : buf_data_q;
        starve_d    = (clear || load) ? 4'd0 :
                      (buf_valid_q && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            starve_q    <= 4'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            starve_q    <= starve_d;
        end
        buf_rd_q   <= buf_rd_d;
        buf_data_q <= buf_data_d;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized stimulus against a queue-based reference model;
// expected port behaviour is queued per cycle and compared by an independent monitor.
module tb_wb_port_arbiter;
    localparam int XLEN = 32;
    localparam int LIM  = 4;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wb_valid = 1'b0, mc_valid = 1'b0;
    logic [4:0]      wb_rd = '0, mc_rd = '0;
    logic [XLEN-1:0] wb_data = '0, mc_data = '0;
    logic            mc_ready, pipe_stall, rf_we, waw_drop;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    always #5 clk = ~clk;
    wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
        .mc_ready(mc_ready), .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .waw_drop(waw_drop)
    );
    typedef struct {
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        logic            stall;
        logic            ready;
        logic            waw;
    } exp_t;
    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;
    // reference model: the held multi-cycle result as a list of at most one entry with its age
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        int              age;
    } held_t;
    held_t held[$];
    bit last_stall = 0;
    bit last_ready = 0;
    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask
    exp_t e_mon;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            check("rf_we", 32'(rf_we), 32'(e_mon.we));
            check("mc_ready", 32'(mc_ready), 32'(e_mon.ready));
            check("pipe_stall", 32'(pipe_stall), 32'(e_mon.stall));
            check("waw_drop", 32'(waw_drop), 32'(e_mon.waw));
            if (e_mon.we) begin
                check("rf_waddr", 32'(rf_waddr), 32'(e_mon.addr));
                check("rf_wdata", rf_wdata, e_mon.data);
            end
        end
    end
    task automatic cycle(input logic r, input logic wv, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                         input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md);
        exp_t e;
        bit   has, preq, mreq, drained, killed;
        rst = r; wb_valid = wv; wb_rd = wrd; wb_data = wd;
        mc_valid = mv; mc_rd = mrd; mc_data = md;
        has = held.size() > 0;
        e = '{we: 1'b0, addr: 5'd0, data: '0, stall: 1'b0, ready: !r && !has, waw: 1'b0};
        preq = !r && wv && wrd != 0;
        mreq = e.ready && mv && mrd != 0;
        drained = 0;
        killed = 0;
        if (!r) begin
            if (has && held[0].age >= LIM) begin
                e.we = 1; e.addr = held[0].rd; e.data = held[0].data; e.stall = preq; drained = 1;
            end else if (preq) begin
                e.we = 1; e.addr = wrd; e.data = wd;
                killed = has && held[0].rd == wrd;
                e.waw = killed || (mreq && mrd == wrd);
            end else if (has) begin
                e.we = 1; e.addr = held[0].rd; e.data = held[0].data; drained = 1;
            end else if (mreq) begin
                e.we = 1; e.addr = mrd; e.data = md;
            end
        end
        exp_q.push_back(e);
        last_stall = e.stall;
        last_ready = e.ready;
        @(posedge clk);
        #1;
        if (r || drained || killed) held.delete();
        else if (mreq && preq && mrd != wrd) held.push_back('{rd: mrd, data: md, age: 0});
        else if (has && held[0].age < LIM) held[0].age++;
    endtask
    task automatic idle();
        cycle(0, 0, 5'd0, '0, 0, 5'd0, '0);
    endtask
    logic            r_wv, r_mv, r_rst;
    logic [4:0]      r_wrd, r_mrd;
    logic [XLEN-1:0] r_wd, r_md;
    initial begin
        @(posedge clk);
        #1;
        cycle(1, 0, 5'd0, '0, 0, 5'd0, '0);
        cycle(1, 1, 5'd4, 32'h1, 1, 5'd4, 32'h2);
        idle();
        cycle(0, 0, 5'd0, '0, 1, 5'd5, 32'hDEADBEEF);
        idle();
        cycle(0, 1, 5'd3, 32'hAAAA0003, 1, 5'd7, 32'h77777777);
        idle();
        idle();
        cycle(0, 1, 5'd8, 32'h8, 1, 5'd9, 32'h99999999);
        for (int i = 1; i <= 6; ) begin
            cycle(0, 1, 5'(i), 32'(i * 16), 0, 5'd0, '0);
            if (!last_stall) i++;
        end
        idle();
        cycle(0, 1, 5'd2, 32'h2, 1, 5'd12, 32'hBADBAD12);
        cycle(0, 1, 5'd12, 32'h11, 0, 5'd0, '0);
        idle();
        idle();
        cycle(0, 1, 5'd6, 32'h6, 1, 5'd6, 32'h66);
        cycle(0, 1, 5'd0, 32'h5, 1, 5'd0, 32'h55);
        idle();
        cycle(0, 1, 5'd1, 32'h1, 1, 5'd20, 32'h20202020);
        cycle(0, 1, 5'd2, 32'h2, 0, 5'd0, '0);
        cycle(0, 1, 5'd3, 32'h3, 0, 5'd0, '0);
        cycle(1, 1, 5'd4, 32'h4, 0, 5'd0, '0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 5'(10 + i), 32'(i), 0, 5'd0, '0);
        idle();
        cycle(0, 1, 5'd1, 32'h1, 1, 5'd21, 32'h21);
        for (int i = 0; i < 6; i++) cycle(0, 1, 5'(2 + i), 32'(i), 0, 5'd0, '0);
        idle();
        r_wv = 0; r_mv = 0; r_wrd = 0; r_mrd = 0; r_wd = 0; r_md = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                r_wv = $urandom_range(0, 3) != 0;
                r_wrd = 5'($urandom_range(0, 7));
                r_wd = $urandom;
            end
            if (!(r_mv && !last_ready)) begin
                r_mv = $urandom_range(0, 2) == 0;
                r_mrd = 5'($urandom_range(0, 7));
                r_md = $urandom;
            end
            r_rst = $urandom_range(0, 99) == 0;
            cycle(r_rst, r_wv, r_wrd, r_wd, r_mv, r_mrd, r_md);
        end
        idle();
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the MEM/WB pipeline writeback and one multi-cycle result producer (divider or long-latency load unit) that completes out of band. A one-entry holding buffer absorbs a multi-cycle result that loses arbitration. An aging counter guarantees the buffered result is written within a bounded time by stalling the pipeline. The block sits between the MEM/WB register outputs (after the mem_to_reg mux) and the register file write port.

## Interface

**Parameters**
- `XLEN`, 32: data width.
- `STARVE_LIMIT`, 4: number of cycles a buffered result may lose arbitration before it is forced. Legal range 1-15.

**Ports**
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `wb_valid`  input  1  MEM/WB write request (the stage's reg_write).
- `wb_rd`  input  5  MEM/WB destination register.
- `wb_data`  input  XLEN  MEM/WB write data, already muxed.
- `mc_valid`  input  1  multi-cycle result valid.
- `mc_rd`  input  5  multi-cycle destination register.
- `mc_data`  input  XLEN  multi-cycle result.
- `mc_ready`  output  1  block can accept a multi-cycle result this cycle.
- `pipe_stall`  output  1  hold MEM/WB and all upstream stages this cycle.
- `rf_we`  output  1  register-file write enable.
- `rf_waddr`  output  5  register-file write address.
- `rf_wdata`  output  XLEN  register-file write data.
- `waw_drop`  output  1  one-cycle pulse: the buffered result was discarded (WAW).

## Operation

**State.** The block keeps the following registers:
- `buf_valid`, `buf_rd`, `buf_data`: the one-entry holding buffer.
- `starve_cnt`: 4 bits, saturating at STARVE_LIMIT.

**Request qualification.**
- `p_req` = `wb_valid` & (`wb_rd` != 0).
- `m_req` = `mc_valid` & `mc_ready` & (`mc_rd` != 0).
- A multi-cycle handshake with `mc_rd` = 0 is consumed and discarded.
- No x0 write ever reaches the port.

**Handshake.**
- `mc_ready` = !`buf_valid` & !`rst`.
- Transfer occurs when `mc_valid` & `mc_ready`.
- The producer must hold `mc_*` stable while `mc_valid` & !`mc_ready`.

**Grant priority**, combinational and evaluated every cycle:
1. `buf_valid` & (`starve_cnt` == STARVE_LIMIT): grant the buffer. If `p_req`, assert `pipe_stall`; the pipeline re-presents the same write next cycle.
2. `p_req`: grant the pipeline.
3. `buf_valid`: grant the buffer.
4. `m_req`: bypass. The incoming result is written directly this cycle and never buffered.
5. Otherwise `rf_we` = 0.

**Write port.** `rf_we`, `rf_waddr` and `rf_wdata` are driven combinationally from the granted source.

**Buffer update** at the clock edge:
- Buffer granted: `buf_valid` <= 0, `starve_cnt` <= 0.
- `m_req` and the bypass was not taken: load the buffer with `mc_rd`/`mc_data` and set `starve_cnt` <= 0. This happens only when the buffer was empty.
- Buffer valid and not granted: `starve_cnt` <= min(`starve_cnt` + 1, STARVE_LIMIT).

**WAW kill.**
- Issue logic guarantees any pipeline write colliding with an outstanding multi-cycle `rd` is younger.
- If the pipeline is granted with `wb_rd` == `buf_rd` & `buf_valid`: clear the buffer, clear `starve_cnt`, pulse `waw_drop` that cycle.
- If the pipeline is granted and `m_req` arrives the same cycle with `mc_rd` == `wb_rd`: the incoming result is not buffered and `waw_drop` pulses.

**Reset.**
- `buf_valid` = 0 and `starve_cnt` = 0.
- While `rst` is high: `rf_we` = 0, `pipe_stall` = 0, `mc_ready` = 0, `waw_drop` = 0.
- Reset mid-operation discards any buffered result without writing it.

## Timing

- Pipeline write to port: 0 cycles (same cycle as `wb_valid`).
- Bypassed multi-cycle write: 0 cycles.
- Buffered result written at the latest STARVE_LIMIT + 1 cycles after capture. When it is forced, `pipe_stall` is high for exactly one cycle.
- `mc_ready` deasserts the cycle after a capture and reasserts the cycle after the buffer drains. The minimum period between back-to-back buffered captures is 2 cycles.
- `pipe_stall` is a combinational function of registered state plus `wb_valid`/`wb_rd`. It never depends on `mc_valid`.
- `waw_drop` is combinational and valid in the kill cycle only.

## Test plan

1. **Bypass.** Pipeline idle; `mc_valid`=1, `mc_rd`=5, `mc_data`=0xDEADBEEF → same cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF; buffer stays empty.
2. **Buffer then drain.** `wb_valid`=1, `wb_rd`=3 and `mc_valid`=1, `mc_rd`=7 in the same cycle → x3 is written and x7 is buffered; next cycle `mc_ready`=0. Pipeline goes idle in the following cycle → x7 is written, then `mc_ready`=1.
3. **Starvation.** STARVE_LIMIT=4; x9 buffered; pipeline writes x1..x6 on consecutive cycles → x1..x4 are written. On the 5th cycle x9 is written with `pipe_stall`=1 and the x5 request held. x5 and x6 follow on the next two cycles.
4. **WAW.** x12 buffered; pipeline writes x12=0x11 → port writes 0x11 and `waw_drop`=1; the buffer is empty and x12 is never rewritten with the buffered data.
5. **x0.** `wb_rd`=0 with `wb_valid`=1 and `mc_rd`=0 with `mc_valid`=1 → `rf_we`=0; the mc handshake completes and the buffer stays empty.
6. **Reset mid-operation.** x20 buffered with `starve_cnt`=2; `rst` pulsed for 1 cycle → no x20 write occurs. After `rst` falls, `mc_ready`=1, `pipe_stall`=0, `starve_cnt`=0.
